// File: rtl/anti_theft_controller_if.sv
// Signal bundle between the anti-theft controller and its surroundings:
// sensor/strobe inputs toward the controller, siren/display outputs back.
interface anti_theft_controller_if #(parameter int CNT_W = 4);
  logic             one_hz_enable;
  logic             ignition;
  logic             hidden_switch;
  logic             door_driver;
  logic             door_pass;
  logic             enable_siren;
  logic             status_led;
  logic [2:0]       state_out;
  logic [CNT_W-1:0] time_left;

  modport master (
    output one_hz_enable, ignition, hidden_switch, door_driver, door_pass,
    input  enable_siren, status_led, state_out, time_left
  );

  modport slave (
    input  one_hz_enable, ignition, hidden_switch, door_driver, door_pass,
    output enable_siren, status_led, state_out, time_left
  );
endinterface

// File: rtl/anti_theft_controller.sv
// Anti-theft central FSM: arming/entry-delay/alarm timers counted in seconds
// from the shared one_hz_enable strobe; all outputs registered.
//   state      | meaning
//   ARMED      | watching doors, LED blinks at 1 Hz
//   TRIGGERED  | entry delay running, waiting for disarm
//   ALARM      | siren on, held while any door is open
//   DISARMED   | owner authenticated, waiting for ignition off
//   WAIT_OPEN  | ignition off, waiting for driver to leave
//   WAIT_CLOSE | driver door opened, waiting for all doors closed
//   ARM_DELAY  | doors closed, counting down to re-arm
module anti_theft_controller #(
  parameter int T_ARM_DELAY       = 6,
  parameter int T_DRIVER_DELAY    = 8,
  parameter int T_PASSENGER_DELAY = 15,
  parameter int T_ALARM_ON        = 10,
  parameter int CNT_W             = 4
) (
  input logic                     clock,
  input logic                     reset,
  anti_theft_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    TRIGGERED  = 3'd1,
    ALARM      = 3'd2,
    DISARMED   = 3'd3,
    WAIT_OPEN  = 3'd4,
    WAIT_CLOSE = 3'd5,
    ARM_DELAY  = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] LD_ARM  = CNT_W'(T_ARM_DELAY);
  localparam logic [CNT_W-1:0] LD_DRV  = CNT_W'(T_DRIVER_DELAY);
  localparam logic [CNT_W-1:0] LD_PASS = CNT_W'(T_PASSENGER_DELAY);
  localparam logic [CNT_W-1:0] LD_ALM  = CNT_W'(T_ALARM_ON);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             led_q, led_d;
  logic             siren_q, siren_d;

  logic disarm, door_any, strobe, last_sec;
  assign disarm   = bus.ignition & bus.hidden_switch;
  assign door_any = bus.door_driver | bus.door_pass;
  assign strobe   = bus.one_hz_enable;
  assign last_sec = (timer_q == ONE);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ARMED: begin
        if (disarm) begin
          state_d = DISARMED;
          timer_d = '0;
        end else if (bus.door_driver) begin
          state_d = TRIGGERED;
          timer_d = LD_DRV;
        end else if (bus.door_pass) begin
          state_d = TRIGGERED;
          timer_d = LD_PASS;
        end
      end
      TRIGGERED: begin
        if (disarm) begin
          state_d = DISARMED;
          timer_d = '0;
        end else if (strobe) begin
          if (last_sec) begin
            state_d = ALARM;
            timer_d = LD_ALM;
          end else begin
            timer_d = timer_q - ONE;
          end
        end
      end
      ALARM: begin
        if (disarm) begin
          state_d = DISARMED;
          timer_d = '0;
        end else if (door_any) begin
          timer_d = LD_ALM;
        end else if (strobe) begin
          if (last_sec) state_d = ARMED;
          timer_d = timer_q - ONE;
        end
      end
      DISARMED: begin
        if (!bus.ignition) state_d = WAIT_OPEN;
      end
      WAIT_OPEN: begin
        if (bus.ignition)         state_d = DISARMED;
        else if (bus.door_driver) state_d = WAIT_CLOSE;
      end
      WAIT_CLOSE: begin
        if (bus.ignition) begin
          state_d = DISARMED;
        end else if (!door_any) begin
          state_d = ARM_DELAY;
          timer_d = LD_ARM;
        end
      end
      ARM_DELAY: begin
        if (bus.ignition) begin
          state_d = DISARMED;
          timer_d = '0;
        end else if (door_any) begin
          state_d = WAIT_CLOSE;
          timer_d = '0;
        end else if (strobe) begin
          if (last_sec) state_d = ARMED;
          timer_d = timer_q - ONE;
        end
      end
      default: begin
        state_d = ARMED;
        timer_d = '0;
      end
    endcase

    // LED blinks only while staying armed; any entry into ARMED starts it dark
    led_d = 1'b0;
    if (state_d == TRIGGERED || state_d == ALARM) led_d = 1'b1;
    else if (state_d == ARMED && state_q == ARMED) led_d = led_q ^ strobe;

    siren_d = (state_d == ALARM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARMED;
      timer_q <= '0;
      led_q   <= 1'b0;
      siren_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      led_q   <= led_d;
      siren_q <= siren_d;
    end
  end

  assign bus.enable_siren = siren_q;
  assign bus.status_led   = led_q;
  assign bus.state_out    = 3'(state_q);
  assign bus.time_left    = timer_q;

endmodule
